// File: rtl/mppt_pwm_gate_driver.sv
// Complementary 256-clock PWM gate driver with shadowed duty, clamp and dead time; outputs registered (1 clk after cnt).
// No backpressure: duty_in is sampled once per period (or continuously while disabled), counter free-runs while enabled.
module mppt_pwm_gate_driver #(
    parameter int DEAD_TIME = 4,
    parameter int DUTY_MIN  = 8,
    parameter int DUTY_MAX  = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty_in,
    input  logic       enable,
    output logic       gate_hi,
    output logic       gate_lo,
    output logic       period_start,
    output logic       adc_trig,
    output logic [7:0] duty_active
);

    localparam logic [4:0] RUN_SAT = 5'(DEAD_TIME + 1);
    localparam logic [7:0] MAX_C   = 8'(DUTY_MAX);
    localparam logic [7:0] MIN_C   = 8'(DUTY_MIN);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] duty_active_q, duty_active_d;
    logic [4:0] run_q, run_d;
    logic       raw_prev_q, raw_prev_d;
    logic       gate_hi_q, gate_hi_d;
    logic       gate_lo_q, gate_lo_d;
    logic       period_start_q, period_start_d;
    logic       adc_trig_q, adc_trig_d;
    logic [7:0] dc;
    logic [7:0] adc_pt;
    logic       raw;

    always_comb begin
        dc     = (duty_in > MAX_C) ? MAX_C : ((duty_in < MIN_C) ? 8'd0 : duty_in);
        raw    = (cnt_q < duty_active_q);
        // Zero duty has no on-time, so sample mid-period instead.
        adc_pt = (duty_active_q == 8'd0) ? 8'd128 : (duty_active_q >> 1);

        cnt_d         = enable ? (cnt_q + 8'd1) : 8'd0;
        duty_active_d = (!enable || (cnt_q == 8'hFF)) ? dc : duty_active_q;
        raw_prev_d    = raw;

        // run_d counts cycles of unchanged raw including this one.
        if (!enable) begin
            run_d = 5'd0;
        end else if (raw != raw_prev_q) begin
            run_d = 5'd1;
        end else if (run_q < RUN_SAT) begin
            run_d = run_q + 5'd1;
        end else begin
            run_d = run_q;
        end

        gate_hi_d      = enable && raw  && (run_d == RUN_SAT);
        gate_lo_d      = enable && !raw && (run_d == RUN_SAT);
        period_start_d = enable && (cnt_q == 8'd0);
        adc_trig_d     = enable && (cnt_q == adc_pt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= 8'd0;
            duty_active_q  <= 8'd0;
            run_q          <= 5'd0;
            raw_prev_q     <= 1'b0;
            gate_hi_q      <= 1'b0;
            gate_lo_q      <= 1'b0;
            period_start_q <= 1'b0;
            adc_trig_q     <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_active_q  <= duty_active_d;
            run_q          <= run_d;
            raw_prev_q     <= raw_prev_d;
            gate_hi_q      <= gate_hi_d;
            gate_lo_q      <= gate_lo_d;
            period_start_q <= period_start_d;
            adc_trig_q     <= adc_trig_d;
        end
    end

    assign gate_hi      = gate_hi_q;
    assign gate_lo      = gate_lo_q;
    assign period_start = period_start_q;
    assign adc_trig     = adc_trig_q;
    assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_mppt_pwm_gate_driver.sv
// Bench for mppt_pwm_gate_driver: per-cycle reference queue plus per-period hand-computed waveform statistics.
module tb_mppt_pwm_gate_driver;

    localparam int DT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] duty_in = 8'd0;
    logic       gate_hi, gate_lo, period_start, adc_trig;
    logic [7:0] duty_active;

    mppt_pwm_gate_driver #(.DEAD_TIME(DT), .DUTY_MIN(8), .DUTY_MAX(240)) dut (
        .clk(clk), .rst_n(rst_n), .duty_in(duty_in), .enable(enable),
        .gate_hi(gate_hi), .gate_lo(gate_lo), .period_start(period_start),
        .adc_trig(adc_trig), .duty_active(duty_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hi;
        logic       lo;
        logic       ps;
        logic       at;
        logic [7:0] da;
    } cyc_t;

    typedef struct packed {
        int hi;
        int lo;
        int first;
        int adc_idx;
        int adc_n;
        int da;
    } win_t;

    cyc_t exp_q[$];
    win_t win_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic [7:0] m_cnt, m_da;
    logic       m_hi, m_lo, m_ps, m_at;
    logic [DT:0] h_raw, h_en;

    function automatic logic [7:0] clamp(input logic [7:0] d);
        if (d > 8'd240) return 8'd240;
        if (d < 8'd8) return 8'd0;
        return d;
    endfunction

    task automatic model_reset();
        m_cnt = 8'd0; m_da = 8'd0;
        m_hi = 1'b0; m_lo = 1'b0; m_ps = 1'b0; m_at = 1'b0;
        h_raw = '0; h_en = '0;
    endtask

    task automatic model_clock();
        logic raw;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw   = (m_cnt < m_da);
        h_raw = {h_raw[DT-1:0], raw};
        h_en  = {h_en[DT-1:0], enable};
        m_hi  = enable && (h_en == '1) && (h_raw == '1);
        m_lo  = enable && (h_en == '1) && (h_raw == '0);
        m_ps  = enable && (m_cnt == 8'd0);
        m_at  = enable && (m_cnt == ((m_da == 8'd0) ? 8'd128 : {1'b0, m_da[7:1]}));
        if (!enable || m_cnt == 8'd255) m_da = clamp(duty_in);
        m_cnt = enable ? m_cnt + 8'd1 : 8'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_clock();
    endtask

    task automatic apply(input logic en, input logic [7:0] d, input logic rn);
        enable  = en;
        duty_in = d;
        rst_n   = rn;
        if (!rn) model_reset();
        exp_q.push_back(cyc_t'({m_hi, m_lo, m_ps, m_at, m_da}));
    endtask

    task automatic run(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) begin
            tick();
            apply(1'b1, d, 1'b1);
        end
    endtask

    task automatic gap(input logic [7:0] d);
        for (int i = 0; i < 4; i++) begin
            tick();
            apply(1'b0, d, 1'b1);
        end
    endtask

    task automatic push_win(input int hi, input int lo, input int first, input int adc, input int da);
        win_q.push_back(win_t'({hi, lo, first, adc, 1, da}));
    endtask

    // Monitor
    cyc_t e_c, a_c;
    win_t e_w, a_w;
    int   low_run = 0;
    logic p_hi = 1'b0, p_lo = 1'b0;
    logic w_ok = 1'b0;
    int   w_len = 0, w_hi = 0, w_lo = 0, w_first = -1, w_adc = -1, w_adcn = 0, w_da = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e_c = exp_q.pop_front();
                a_c = {gate_hi, gate_lo, period_start, adc_trig, duty_active};
                n_checks++;
                if (a_c !== e_c) begin
                    n_errors++;
                    $display("FAIL cycle_outputs t=%0t got hi/lo/ps/at/da=%b%b%b%b/%0d want %b%b%b%b/%0d",
                             $time, a_c.hi, a_c.lo, a_c.ps, a_c.at, a_c.da, e_c.hi, e_c.lo, e_c.ps, e_c.at, e_c.da);
                end
            end
            n_checks++;
            if (gate_hi && gate_lo) begin
                n_errors++;
                $display("FAIL gate_overlap t=%0t got both high want never", $time);
            end
            if ((gate_hi && !p_hi) || (gate_lo && !p_lo)) begin
                n_checks++;
                if (low_run < DT) begin
                    n_errors++;
                    $display("FAIL dead_time t=%0t got %0d low clocks want >= %0d", $time, low_run, DT);
                end
            end
            low_run = (!gate_hi && !gate_lo) ? low_run + 1 : 0;
            p_hi = gate_hi;
            p_lo = gate_lo;

            if (period_start) begin
                if (w_ok && w_len == 256 && win_q.size() > 0) begin
                    e_w = win_q.pop_front();
                    a_w = win_t'({w_hi, w_lo, w_first, w_adc, w_adcn, w_da});
                    n_checks++;
                    if (a_w != e_w) begin
                        n_errors++;
                        $display("FAIL period_stats t=%0t got hi=%0d lo=%0d first=%0d adc=%0d/%0d da=%0d want hi=%0d lo=%0d first=%0d adc=%0d/%0d da=%0d",
                                 $time, a_w.hi, a_w.lo, a_w.first, a_w.adc_idx, a_w.adc_n, a_w.da,
                                 e_w.hi, e_w.lo, e_w.first, e_w.adc_idx, e_w.adc_n, e_w.da);
                    end
                end
                w_ok = 1'b1; w_len = 0; w_hi = 0; w_lo = 0;
                w_first = -1; w_adc = -1; w_adcn = 0; w_da = int'(duty_active);
            end
            if (gate_hi) begin
                if (w_first < 0) w_first = w_len;
                w_hi++;
            end
            if (gate_lo) w_lo++;
            if (adc_trig) begin
                w_adc = w_len;
                w_adcn++;
            end
            w_len++;
            if (!enable || !rst_n) w_ok = 1'b0;
        end
    end

    // Stimulus
    initial begin
        logic [7:0] d;
        int         len;
        logic       en;
        model_reset();
        tick();
        apply(1'b0, 8'd0, 1'b0);
        tick();
        apply(1'b0, 8'd0, 1'b0);

        // Steady duty 100: window index i is the output produced while cnt=i
        gap(8'd100);
        for (int i = 0; i < 3; i++) push_win(96, 152, 4, 50, 100);
        run(3 * 256 + 2, 8'd100);

        // Duty change mid-period only takes effect next period
        gap(8'd100);
        push_win(96, 152, 4, 50, 100);
        push_win(96, 152, 4, 50, 100);
        push_win(56, 192, 4, 30, 60);
        d = 8'd100;
        for (int i = 0; i < 3 * 256 + 2; i++) begin
            tick();
            if (i >= 256 && m_cnt == 8'd30) d = 8'd60;
            apply(1'b1, d, 1'b1);
        end

        // Clamp high and clamp-to-zero
        gap(8'd250);
        push_win(236, 12, 4, 120, 240);
        push_win(236, 12, 4, 120, 240);
        run(2 * 256 + 2, 8'd250);
        gap(8'd5);
        push_win(0, 252, -1, 128, 0);
        push_win(0, 256, -1, 128, 0);
        run(2 * 256 + 2, 8'd5);

        // Enable dropped at cnt=70, then re-enabled
        gap(8'd100);
        push_win(96, 152, 4, 50, 100);
        run(256 + 70, 8'd100);
        tick();
        apply(1'b0, 8'd100, 1'b1);
        gap(8'd100);
        push_win(96, 152, 4, 50, 100);
        run(256 + 2, 8'd100);

        // Asynchronous reset at cnt=40 while gate_hi is high
        gap(8'd100);
        push_win(96, 152, 4, 50, 100);
        push_win(0, 252, -1, 128, 0);
        push_win(96, 152, 4, 50, 100);
        run(256 + 40, 8'd100);
        for (int i = 0; i < 4; i++) begin
            tick();
            apply(1'b1, 8'd100, 1'b0);
        end
        tick();
        apply(1'b1, 8'd100, 1'b1);
        run(2 * 256 + 1, 8'd100);

        // Random duty and enable toggling
        gap(8'd0);
        for (int blk = 0; blk < 200; blk++) begin
            len = $urandom_range(1, 300);
            en  = ($urandom_range(0, 9) != 0);
            d   = 8'($urandom_range(0, 255));
            for (int i = 0; i < len; i++) begin
                tick();
                apply(en, d, 1'b1);
            end
        end

        gap(8'd0);
        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL cycle_queue_drain got %0d pending want 0", exp_q.size());
        end
        n_checks++;
        if (win_q.size() != 0) begin
            n_errors++;
            $display("FAIL period_queue_drain got %0d pending want 0", win_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
